// File: rtl/pipe_stage_ctrl.sv
// Two-entry (head + skid) pipeline stage with load-use interlock and stall counter.
// Latency 1 cycle from EMPTY; in_ready is registered occupancy, masked only by flush and hazard.
module pipe_stage_ctrl #(
  parameter int STALL_W = 16
) (
  input  logic               system1000,
  input  logic               system1000_rstn,
  input  logic               in_valid,
  input  logic [55:0]        in_bundle,
  output logic               in_ready,
  output logic               out_valid,
  output logic [55:0]        out_bundle,
  input  logic               out_ready,
  input  logic               flush,
  output logic [STALL_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [6:0]  dst;
    logic [6:0]  src;
    logic        wr_en;
    logic [15:0] imm;
    logic [7:0]  opcode;
    logic        is_load;
    logic [15:0] data;
  } hdr_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  state_e             state_q, state_d;
  hdr_t               head_q, head_d;
  hdr_t               skid_q, skid_d;
  logic               in_ready_q, in_ready_d;
  logic [6:0]         last_dst_q, last_dst_d;
  logic               last_ld_q, last_ld_d;
  logic [STALL_W-1:0] stall_q, stall_d;

  hdr_t in_hdr;
  logic hazard, accept, drain;

  assign in_hdr     = hdr_t'(in_bundle);
  // The bubble is the hazard cycle itself; last_ld is cleared so the retry goes through.
  assign hazard     = in_valid && last_ld_q && (in_hdr.src == last_dst_q);
  assign in_ready   = in_ready_q && !flush && !hazard;
  assign out_valid  = (state_q != EMPTY);
  assign accept     = in_valid && in_ready;
  assign drain      = out_valid && out_ready;
  assign out_bundle = head_q;
  assign stall_cnt  = stall_q;

  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    skid_d     = skid_q;
    last_dst_d = last_dst_q;
    last_ld_d  = last_ld_q;
    stall_d    = stall_q;

    if (flush) begin
      state_d   = EMPTY;
      head_d    = '0;
      skid_d    = '0;
      last_ld_d = 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            head_d  = in_hdr;
          end
        end
        ONE: begin
          if (accept && drain) begin
            head_d = in_hdr;
          end else if (accept) begin
            state_d = FULL;
            skid_d  = in_hdr;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            state_d = ONE;
            head_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase

      if (accept) begin
        last_dst_d = in_hdr.dst;
        last_ld_d  = in_hdr.wr_en && in_hdr.is_load;
      end else if (hazard) begin
        last_ld_d = 1'b0;
      end
    end

    in_ready_d = (state_d != FULL);

    if (in_valid && !in_ready && (stall_q != '1)) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state_q    <= EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
      last_dst_q <= '0;
      last_ld_q  <= 1'b0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      last_dst_q <= last_dst_d;
      last_ld_q  <= last_ld_d;
      stall_q    <= stall_d;
    end
  end

endmodule
